// File: rtl/input_conditioner_bank_pkg.sv
// Constants shared by the input conditioner bank, the shift-register midpoint and the board top.
// Channel indices name the physical inputs; the defaults size the bank.
package input_conditioner_bank_pkg;

    localparam int CH_BTN0 = 0;
    localparam int CH_SW0  = 1;
    localparam int CH_SW1  = 2;

    localparam int DEFAULT_CHANNELS = 3;
    localparam int DEFAULT_WAITTIME = 3;

endpackage

// File: rtl/input_conditioner_channel.sv
// One input channel: two-flop synchronizer, debounce counter and registered edge pulses.
// A new level is accepted after WAITTIME consecutive synced cycles that disagree with it.
module input_conditioner_channel
    import input_conditioner_bank_pkg::*;
#(
    parameter int WAITTIME = DEFAULT_WAITTIME
) (
    input  logic clk,
    input  logic reset,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam int CW = $clog2(WAITTIME + 1);
    localparam logic [CW-1:0] LAST = CW'(WAITTIME - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] counter_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0      <= 1'b0;
            sync_p1      <= 1'b0;
            counter_p2   <= '0;
            conditioned  <= 1'b0;
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;
        end else begin
            // synchronizer stages
            sync_p0      <= noisysignal;
            sync_p1      <= sync_p0;
            // debounce stage: any agreeing sample restarts the count
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;
            if (sync_p1 == conditioned) begin
                counter_p2 <= '0;
            end else if (counter_p2 == LAST) begin
                conditioned  <= sync_p1;
                counter_p2   <= '0;
                positiveedge <= sync_p1;
                negativeedge <= ~sync_p1;
            end else begin
                counter_p2 <= counter_p2 + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner_bank.sv
// Bank of independent input conditioners, one per raw board input.
// Bit order follows the channel index constants in input_conditioner_bank_pkg.
module input_conditioner_bank
    import input_conditioner_bank_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WAITTIME = DEFAULT_WAITTIME
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        input_conditioner_channel #(
            .WAITTIME (WAITTIME)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .noisysignal  (noisysignal[ch]),
            .conditioned  (conditioned[ch]),
            .positiveedge (positiveedge[ch]),
            .negativeedge (negativeedge[ch])
        );
    end

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Self-checking bench for input_conditioner_bank (3 channels, WAITTIME=3, 20 ns clock).
// Reference: a level is accepted once the last WAITTIME synced samples all differ from it.
module tb_input_conditioner_bank;

    localparam int CH = 3;
    localparam int W  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] noisysignal = '0;
    logic [CH-1:0] conditioned, positiveedge, negativeedge;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner_bank #(.CHANNELS(CH), .WAITTIME(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .noisysignal  (noisysignal),
        .conditioned  (conditioned),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge)
    );

    always #10 clk = ~clk;

    // Reference model: history of every sampled input since reset.
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_cond, m_pos, m_neg;

    task automatic model_reset();
        hist.delete();
        m_cond = '0;
        m_pos  = '0;
        m_neg  = '0;
    endtask

    // Input sampled at edge k reaches the debounce decision two edges later.
    task automatic model_edge(input logic [CH-1:0] n);
        int k;
        int idx;
        bit all_differ;
        logic v;
        hist.push_back(n);
        k = hist.size();
        for (int c = 0; c < CH; c++) begin
            all_differ = 1'b1;
            for (int j = 0; j < W; j++) begin
                idx = k - 3 - j;
                v = (idx >= 0) ? hist[idx][c] : 1'b0;
                if (v == m_cond[c]) all_differ = 1'b0;
            end
            m_pos[c] = 1'b0;
            m_neg[c] = 1'b0;
            if (all_differ) begin
                m_cond[c] = ~m_cond[c];
                m_pos[c]  = m_cond[c];
                m_neg[c]  = ~m_cond[c];
            end
        end
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one input value for one clock edge and compare against the model.
    task automatic step(input logic [CH-1:0] n);
        noisysignal = n;
        @(posedge clk);
        model_edge(n);
        #1;
        check("conditioned", conditioned, m_cond);
        check("positiveedge", positiveedge, m_pos);
        check("negativeedge", negativeedge, m_neg);
    endtask

    // Async reset asserted in the high phase; outputs must clear without a clock edge.
    task automatic async_reset(input int hold_cycles);
        #4;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_cond_now", conditioned, '0);
        check("rst_pos_now", positiveedge, '0);
        check("rst_neg_now", negativeedge, '0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_cond_hold", conditioned, '0);
            check("rst_pulse_hold", positiveedge | negativeedge, '0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse-shape checker: never pos and neg together, never a pulse two cycles running.
    logic [CH-1:0] prev_pos = '0, prev_neg = '0;
    always @(negedge clk) begin
        if (!reset) begin
            check("pos_and_neg", positiveedge & negativeedge, '0);
            check("pulse_width", (positiveedge & prev_pos) | (negativeedge & prev_neg), '0);
            prev_pos = positiveedge;
            prev_neg = negativeedge;
        end else begin
            prev_pos = '0;
            prev_neg = '0;
        end
    end

    typedef struct {
        logic [CH-1:0] noisy;
        logic [CH-1:0] cond;
        logic [CH-1:0] pos;
        logic [CH-1:0] neg;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int pulses;
        logic [CH-1:0] v;
        int hold;

        // Clean rise on ch0: conditioned follows on the 5th edge, pulse for that one cycle.
        tbl[0] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[1] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[2] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[3] = '{3'b001, 3'b000, 3'b000, 3'b000};
        tbl[4] = '{3'b001, 3'b001, 3'b001, 3'b000};
        tbl[5] = '{3'b001, 3'b001, 3'b000, 3'b000};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_cond", conditioned, '0);
        check("init_pulses", positiveedge | negativeedge, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].noisy);
            check("tbl_cond", conditioned, tbl[i].cond);
            check("tbl_pos", positiveedge, tbl[i].pos);
            check("tbl_neg", negativeedge, tbl[i].neg);
        end

        // Reset with all inputs high, then full latency after release.
        for (int i = 0; i < 6; i++) step(3'b111);
        check("pre_reset_cond", conditioned, 3'b111);
        async_reset(2);
        for (int e = 1; e <= 6; e++) begin
            step(3'b111);
            if (e == 4) check("rst_e4_cond", conditioned, 3'b000);
            if (e == 5) begin
                check("rst_e5_cond", conditioned, 3'b111);
                check("rst_e5_pos", positiveedge, 3'b111);
            end
        end

        // Bounce on ch0: alternate for 8 cycles, then settle high.
        async_reset(1);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step((i < 8) ? ((i % 2 == 0) ? 3'b001 : 3'b000) : 3'b001);
            pulses += int'(positiveedge[0]);
            if (i == 11) check("bounce_early", conditioned, 3'b000);
            if (i == 12) check("bounce_rise", conditioned, 3'b001);
        end
        check("bounce_pulses", 3'(pulses), 3'd1);

        // Glitch rejection on ch1, then a real fall.
        for (int i = 0; i < 6; i++) step(3'b011);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step(3'b001);
            pulses += int'(positiveedge[1]) + int'(negativeedge[1]);
        end
        for (int i = 0; i < 6; i++) begin
            step(3'b011);
            pulses += int'(positiveedge[1]) + int'(negativeedge[1]);
        end
        check("glitch_cond", conditioned, 3'b011);
        check("glitch_pulses", 3'(pulses), 3'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(3'b001);
            pulses += int'(negativeedge[1]);
        end
        check("fall_cond", conditioned, 3'b001);
        check("fall_pulses", 3'(pulses), 3'd1);

        // Simultaneous: ch1 rises while ch2 falls.
        for (int i = 0; i < 6; i++) step(3'b101);
        check("simul_pre", conditioned, 3'b101);
        for (int e = 1; e <= 6; e++) begin
            step(3'b011);
            if (e == 5) begin
                check("simul_pos", positiveedge, 3'b010);
                check("simul_neg", negativeedge, 3'b100);
                check("simul_cond", conditioned, 3'b011);
            end
        end

        // Reset mid-count discards the pending rise on ch0.
        async_reset(1);
        for (int i = 0; i < 4; i++) step(3'b001);
        check("midcount_cond", conditioned, 3'b000);
        async_reset(1);
        for (int e = 1; e <= 6; e++) begin
            step(3'b001);
            if (e == 4) check("midcount_e4", conditioned, 3'b000);
            if (e == 5) begin
                check("midcount_e5", conditioned, 3'b001);
                check("midcount_pos", positiveedge, 3'b001);
            end
        end

        // Random runs of random lengths against the model.
        for (int i = 0; i < 250; i++) begin
            v = 3'($urandom);
            hold = $urandom_range(1, 5);
            for (int j = 0; j < hold; j++) step(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
